// File: rtl/input_conditioner_pkg.sv
// Shared board-level constants for the input conditioning slice.
// Default sizes match the DE-series board: 8 slide switches, KEY[3:1], 50 MHz clock.
package input_conditioner_pkg;

  localparam int unsigned N_SW_DEF            = 8;
  localparam int unsigned N_KEY_DEF           = 3;
  localparam int unsigned CLK_HZ              = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit 2-flop synchroniser plus stable-count debouncer with registered edge pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sampling edge; no backpressure (free-running).
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic rise_pls,
  output logic fall_pls
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // An idle-high input (active-low key) is tracked inverted, so stable is always active-high.
  assign level = sync2 ^ RESET_VAL;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= RESET_VAL;
      sync2    <= RESET_VAL;
      stable   <= 1'b0;
      cnt      <= '0;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      rise_pls <= 1'b0;
      fall_pls <= 1'b0;
      if (level == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable   <= level;
        cnt      <= '0;
        rise_pls <= level;
        fall_pls <= ~level;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Conditions raw slide switches and KEY[3:1] into clean levels plus press/release/change pulses.
// Latency: DEBOUNCE_CYCLES+2 edges per bit; no backpressure, outputs are level/pulse only.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned N_SW            = N_SW_DEF,
  parameter int unsigned N_KEY           = N_KEY_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_KEY-1:0] key_raw_n,
  output logic [N_SW-1:0]  sw_stable,
  output logic [N_KEY-1:0] key_pressed,
  output logic [N_KEY-1:0] key_press_pls,
  output logic [N_KEY-1:0] key_release_pls,
  output logic             sw_changed_pls
);

  logic [N_SW-1:0] sw_rise;
  logic [N_SW-1:0] sw_fall;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_db (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .raw      (sw_raw[i]),
      .stable   (sw_stable[i]),
      .rise_pls (sw_rise[i]),
      .fall_pls (sw_fall[i])
    );
  end

  // Keys idle high; RESET_VAL=1 makes the bit invert, so stable reads as "held".
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
    ) u_db (
      .CLOCK_50 (CLOCK_50),
      .reset_n  (reset_n),
      .raw      (key_raw_n[i]),
      .stable   (key_pressed[i]),
      .rise_pls (key_press_pls[i]),
      .fall_pls (key_release_pls[i])
    );
  end

  // Per-bit pulses are registered, so this OR is a clean single-cycle pulse.
  assign sw_changed_pls = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] sw_raw;
  logic [2:0] key_raw_n;
  logic [7:0] sw_stable;
  logic [2:0] key_pressed;
  logic [2:0] key_press_pls;
  logic [2:0] key_release_pls;
  logic       sw_changed_pls;

  input_conditioner #(
    .N_SW            (8),
    .N_KEY           (3),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .CLOCK_50        (clk),
    .reset_n         (reset_n),
    .sw_raw          (sw_raw),
    .key_raw_n       (key_raw_n),
    .sw_stable       (sw_stable),
    .key_pressed     (key_pressed),
    .key_press_pls   (key_press_pls),
    .key_release_pls (key_release_pls),
    .sw_changed_pls  (sw_changed_pls)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] sw;
    logic [2:0] kp;
    logic [2:0] kpp;
    logic [2:0] krp;
    logic       swc;
  } ev_t;

  ev_t  q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected output event: the new level appears on the 6th edge counting the sampling edge.
  task automatic push(input logic [7:0] sw, input logic [2:0] kp, input logic [2:0] kpp,
                      input logic [2:0] krp, input logic swc);
    ev_t e;
    e.cyc = cyc + 1 + (D + 1);
    e.sw  = sw;
    e.kp  = kp;
    e.kpp = kpp;
    e.krp = krp;
    e.swc = swc;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [7:0] prev_sw = '0;
  logic [2:0] prev_kp = '0;
  ev_t        got;

  // Any pulse or stable-level change is an output event and must match the queue head.
  always @(negedge clk) begin
    if (reset_n && (sw_stable !== prev_sw || key_pressed !== prev_kp ||
                    key_press_pls != 3'b000 || key_release_pls != 3'b000 || sw_changed_pls)) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_event: sw=%0h kp=%0h kpp=%0h krp=%0h swc=%0b at cycle %0d, none expected",
                 sw_stable, key_pressed, key_press_pls, key_release_pls, sw_changed_pls, cyc);
      end else begin
        got = q.pop_front();
        chk("ev_cycle",        cyc,             got.cyc);
        chk("sw_stable",       sw_stable,       got.sw);
        chk("key_pressed",     key_pressed,     got.kp);
        chk("key_press_pls",   key_press_pls,   got.kpp);
        chk("key_release_pls", key_release_pls, got.krp);
        chk("sw_changed_pls",  sw_changed_pls,  got.swc);
      end
    end
    prev_sw = sw_stable;
    prev_kp = key_pressed;
  end

  initial begin
    // 1: reset with inputs active, then qualification after release
    reset_n   = 1'b0;
    sw_raw    = 8'hA5;
    key_raw_n = 3'b000;
    step(3);
    chk("rst_sw_stable",   sw_stable,       8'h00);
    chk("rst_key_pressed", key_pressed,     3'b000);
    chk("rst_press_pls",   key_press_pls,   3'b000);
    chk("rst_release_pls", key_release_pls, 3'b000);
    chk("rst_sw_changed",  sw_changed_pls,  1'b0);
    reset_n = 1'b1;
    push(8'hA5, 3'b111, 3'b111, 3'b000, 1'b1);
    step(10);

    // 2: release all, clean press/release of key 0
    key_raw_n = 3'b111;
    push(8'hA5, 3'b000, 3'b000, 3'b111, 1'b0);
    step(10);
    key_raw_n = 3'b110;
    push(8'hA5, 3'b001, 3'b001, 3'b000, 1'b0);
    step(10);
    key_raw_n = 3'b111;
    push(8'hA5, 3'b000, 3'b000, 3'b001, 1'b0);
    step(10);

    // 3: bounce on sw[3] with 1/2/3-cycle highs, then a clean hold
    sw_raw[3] = 1'b1; step(1);
    sw_raw[3] = 1'b0; step(2);
    sw_raw[3] = 1'b1; step(2);
    sw_raw[3] = 1'b0; step(2);
    sw_raw[3] = 1'b1; step(3);
    sw_raw[3] = 1'b0; step(2);
    sw_raw[3] = 1'b1;
    push(8'hAD, 3'b000, 3'b000, 3'b000, 1'b1);
    step(10);

    // 4: simultaneous multi-bit change
    sw_raw = 8'h00;
    push(8'h00, 3'b000, 3'b000, 3'b000, 1'b1);
    step(10);
    sw_raw    = 8'hFF;
    key_raw_n = 3'b010;
    push(8'hFF, 3'b101, 3'b101, 3'b000, 1'b1);
    step(10);

    // 5: asynchronous reset while sw[0] is mid-count
    sw_raw = 8'h00;
    push(8'h00, 3'b101, 3'b000, 3'b000, 1'b1);
    step(10);
    sw_raw = 8'h01;
    step(4);
    chk("midcount_cnt", 32'(dut.g_sw[0].u_db.cnt), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("async_rst_key_pressed", key_pressed, 3'b000);
    chk("async_rst_sw_stable",   sw_stable,   8'h00);
    chk("async_rst_cnt",         32'(dut.g_sw[0].u_db.cnt), 32'd0);
    step(2);
    reset_n = 1'b1;
    push(8'h01, 3'b101, 3'b101, 3'b000, 1'b1);
    step(10);

    // 6: long hold on key 1 yields one press pulse and an idle counter
    key_raw_n = 3'b111;
    push(8'h01, 3'b000, 3'b000, 3'b101, 1'b0);
    step(10);
    key_raw_n = 3'b101;
    push(8'h01, 3'b010, 3'b010, 3'b000, 1'b0);
    step(5);
    for (int i = 0; i < 10; i++) begin
      step(100);
      chk("hold_cnt", 32'(dut.g_key[1].u_db.cnt), 32'd0);
    end
    key_raw_n = 3'b111;
    push(8'h01, 3'b000, 3'b000, 3'b010, 1'b0);
    step(10);

    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
